// File: rtl/vga_rx.sv
// VGA receive side: recovers pixel coordinates from the timing stream, measures the
// active window, locks after one clean frame and forwards pixels with sof/eol markers.
module vga_rx #(
    parameter int unsigned pixel_bits_p = 4,
    parameter int unsigned x_bits_p     = 10,
    parameter int unsigned y_bits_p     = 10
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         hsync_i,
    input  logic                         vsync_i,
    input  logic                         disp_en_i,
    input  logic [2:0][pixel_bits_p-1:0] data_i,
    output logic                         valid_o,
    output logic [2:0][pixel_bits_p-1:0] data_o,
    output logic [x_bits_p-1:0]          x_o,
    output logic [y_bits_p-1:0]          y_o,
    output logic                         sof_o,
    output logic                         eol_o,
    output logic [x_bits_p-1:0]          h_active_o,
    output logic [y_bits_p-1:0]          v_active_o,
    output logic                         locked_o,
    output logic                         err_o
);

    typedef enum logic [1:0] {SEEK, MEASURE, LOCKED} state_e;

    localparam logic [x_bits_p-1:0] x_max_lp = '1;
    localparam logic [y_bits_p-1:0] y_max_lp = '1;

    state_e                        state_q, state_d;
    logic                          vs1_q, vs2_q, de1_q, de2_q, hs1_q;
    logic [2:0][pixel_bits_p-1:0]  data1_q;
    logic [x_bits_p-1:0]           x_cnt_q, x_cnt_d;
    logic [y_bits_p-1:0]           line_cnt_q, line_cnt_d;
    logic                          h_seen_q, h_seen_d;
    logic [x_bits_p-1:0]           h_active_q, h_active_d;
    logic [y_bits_p-1:0]           v_active_q, v_active_d;
    logic                          valid_q, sof_q, eol_q, locked_q, err_q;
    logic [2:0][pixel_bits_p-1:0]  data_q;
    logic [x_bits_p-1:0]           x_q;
    logic [y_bits_p-1:0]           y_q;

    logic                          vs_start_c, de_rise_c, de_fall_c, err_c, valid_c;
    logic [x_bits_p-1:0]           x_pix_c;
    logic [y_bits_p-1:0]           y_pix_c, line_upd_c;
    logic                          unused_hs_c;

    // hsync is only sampled; line boundaries come from disp_en edges
    assign unused_hs_c = hs1_q;

    assign vs_start_c = vs2_q & ~vs1_q;
    assign de_rise_c  = de1_q & ~de2_q;
    assign de_fall_c  = de2_q & ~de1_q;

    // Coordinates of the pixel currently in stage 1
    assign x_pix_c = de_rise_c  ? '0 : x_cnt_q;
    assign y_pix_c = vs_start_c ? '0 : line_cnt_q;

    // Line count including a de_fall on this cycle, so a coincident vs_start sees it
    assign line_upd_c = (de_fall_c && line_cnt_q != y_max_lp) ? line_cnt_q + y_bits_p'(1)
                                                              : line_cnt_q;

    always_comb begin
        x_cnt_d    = x_cnt_q;
        line_cnt_d = vs_start_c ? '0 : line_upd_c;
        if (de1_q) begin
            x_cnt_d = (x_pix_c == x_max_lp) ? x_pix_c : x_pix_c + x_bits_p'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        err_c      = 1'b0;
        h_seen_d   = h_seen_q;
        h_active_d = h_active_q;
        v_active_d = v_active_q;
        unique case (state_q)
            SEEK: begin
                if (vs_start_c) begin
                    state_d  = MEASURE;
                    h_seen_d = 1'b0;
                end
            end
            MEASURE: begin
                if (de_fall_c) begin
                    if (x_cnt_q == x_max_lp) begin
                        err_c = 1'b1;
                    end else if (!h_seen_q) begin
                        h_active_d = x_cnt_q;
                        h_seen_d   = 1'b1;
                    end else if (x_cnt_q != h_active_q) begin
                        err_c = 1'b1;
                    end
                end
                if (vs_start_c && !err_c) begin
                    if (!h_seen_d || line_upd_c == '0) begin
                        state_d = SEEK;
                    end else begin
                        v_active_d = line_upd_c;
                        state_d    = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (de_fall_c && x_cnt_q != h_active_q)       err_c = 1'b1;
                if (de1_q && y_pix_c >= v_active_q)           err_c = 1'b1;
                if (vs_start_c && line_upd_c != v_active_q)   err_c = 1'b1;
            end
            default: state_d = SEEK;
        endcase
        // An error always wins over any frame transition on the same cycle
        if (err_c) state_d = SEEK;
    end

    assign valid_c = (state_q == LOCKED) & de1_q & ~err_c;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            vs1_q      <= 1'b0;
            vs2_q      <= 1'b0;
            de1_q      <= 1'b0;
            de2_q      <= 1'b0;
            hs1_q      <= 1'b0;
            data1_q    <= '0;
            x_cnt_q    <= '0;
            line_cnt_q <= '0;
            state_q    <= SEEK;
            h_seen_q   <= 1'b0;
            h_active_q <= '0;
            v_active_q <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            vs1_q      <= vsync_i;
            vs2_q      <= vs1_q;
            de1_q      <= disp_en_i;
            de2_q      <= de1_q;
            hs1_q      <= hsync_i;
            data1_q    <= data_i;
            x_cnt_q    <= x_cnt_d;
            line_cnt_q <= line_cnt_d;
            state_q    <= state_d;
            h_seen_q   <= h_seen_d;
            h_active_q <= h_active_d;
            v_active_q <= v_active_d;
            valid_q    <= valid_c;
            if (valid_c) begin
                data_q <= data1_q;
                x_q    <= x_pix_c;
                y_q    <= y_pix_c;
            end
            sof_q    <= valid_c & (x_pix_c == '0) & (y_pix_c == '0);
            eol_q    <= valid_c & (x_pix_c == h_active_q - x_bits_p'(1));
            locked_q <= (state_d == LOCKED);
            err_q    <= err_c;
        end
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign x_o        = x_q;
    assign y_o        = y_q;
    assign sof_o      = sof_q;
    assign eol_o      = eol_q;
    assign h_active_o = h_active_q;
    assign v_active_o = v_active_q;
    assign locked_o   = locked_q;
    assign err_o      = err_q;

endmodule
